// File: rtl/sysbus_master.sv
// Sysbus initiator: single/burst reads and writes to a memory responder on the shared
// tri-state bus, holding ownership via the sequencer arbiter for each ADDR/DATA pair.
module sysbus_master #(
    parameter  int WORD_W = 8,
    parameter  int OP_W   = 3,
    localparam int ADDR_W = WORD_W - OP_W
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] len,
    input  logic [WORD_W-1:0] wdata,
    output logic              busy,
    output logic              beat_ack,
    output logic [WORD_W-1:0] rdata,
    output logic              rvalid,
    output logic              done,
    output logic              bus_req,
    input  logic              bus_grant,
    output logic              load_MAR,
    output logic              MDR_bus,
    output logic              load_MDR,
    output logic              CS,
    output logic              R_NW,
    inout  wire  [WORD_W-1:0] sysbus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ADDR = 2'd2,
        DATA = 2'd3
    } state_t;

    state_t            state;
    logic              is_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] remaining;

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state     <= IDLE;
            is_we     <= 1'b0;
            cur_addr  <= '0;
            remaining <= '0;
            rdata     <= '0;
            rvalid    <= 1'b0;
            done      <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        is_we     <= we;
                        cur_addr  <= addr;
                        remaining <= len;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (bus_grant) state <= ADDR;
                end
                // Grant is not looked at here: once the address is out, the data beat must follow.
                ADDR: state <= DATA;
                DATA: begin
                    if (!is_we) begin
                        rdata  <= sysbus;
                        rvalid <= 1'b1;
                    end
                    if (remaining == '0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        cur_addr  <= cur_addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        state     <= bus_grant ? ADDR : REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus controls are pure decodes of the state register, so req can never glitch them.
    assign busy     = (state != IDLE);
    assign bus_req  = (state != IDLE);
    assign load_MAR = (state == ADDR);
    assign beat_ack = (state == DATA);
    assign CS       = (state == DATA);
    assign R_NW     = (state == DATA) && !is_we;
    assign MDR_bus  = (state == DATA) && !is_we;
    assign load_MDR = (state == DATA) && is_we;

    assign sysbus = (state == ADDR)           ? {{OP_W{1'b0}}, cur_addr} :
                    (state == DATA && is_we)  ? wdata                    :
                                                {WORD_W{1'bz}};

endmodule

// File: tb/tb_sysbus_master.sv
// Bench for sysbus_master: a RAM responder on a pulled-up sysbus plus a reference memory
// that predicts read data, write results, beat counts and phase timing.
module tb_sysbus_master;

    localparam int WORD_W = 8;
    localparam int OP_W   = 3;
    localparam int ADDR_W = 5;

    logic              clock = 1'b0;
    logic              n_reset;
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] len;
    logic [WORD_W-1:0] wdata;
    logic              busy;
    logic              beat_ack;
    logic [WORD_W-1:0] rdata;
    logic              rvalid;
    logic              done;
    logic              bus_req;
    logic              bus_grant;
    logic              load_MAR;
    logic              MDR_bus;
    logic              load_MDR;
    logic              CS;
    logic              R_NW;
    tri1  [WORD_W-1:0] sysbus;

    int checks = 0;
    int errors = 0;

    logic [WORD_W-1:0] mem [32];
    logic [WORD_W-1:0] ref_mem [32];
    logic [ADDR_W-1:0] mar = '0;
    logic              fill_en = 1'b0;
    logic [ADDR_W-1:0] fill_idx = '0;
    logic [WORD_W-1:0] fill_val = '0;

    sysbus_master #(.WORD_W(WORD_W), .OP_W(OP_W)) dut (
        .clock     (clock),
        .n_reset   (n_reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .len       (len),
        .wdata     (wdata),
        .busy      (busy),
        .beat_ack  (beat_ack),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .done      (done),
        .bus_req   (bus_req),
        .bus_grant (bus_grant),
        .load_MAR  (load_MAR),
        .MDR_bus   (MDR_bus),
        .load_MDR  (load_MDR),
        .CS        (CS),
        .R_NW      (R_NW),
        .sysbus    (sysbus)
    );

    always #5 clock = ~clock;

    // Memory responder on the bus.
    always @(posedge clock) begin
        if (fill_en) mem[fill_idx] <= fill_val;
        else if (load_MDR) mem[mar] <= sysbus;
        if (load_MAR) mar <= sysbus[ADDR_W-1:0];
    end
    assign sysbus = MDR_bus ? mem[mar] : {WORD_W{1'bz}};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: grant held, exact timing; 1: random grant; 2: grant dropped in 2nd ADDR; 3: grant withheld 5 cycles
    task automatic run_txn(input logic w, input logic [4:0] a, input logic [4:0] l,
                           input int mode, input bit fixed_wd);
        logic [WORD_W-1:0] wd [32];
        int n, beats, mars, rvs, hold;
        bit after2, finished;
        for (int i = 0; i < 32; i++) wd[i] = fixed_wd ? 8'(8'hA1 + i) : 8'($urandom);
        req = 1'b1; we = w; addr = a; len = l; wdata = wd[0];
        @(posedge clock); #1;
        req = 1'b0; we = 1'($urandom); addr = 5'($urandom); len = 5'($urandom);
        n = 0; beats = 0; mars = 0; rvs = 0; hold = 0; after2 = 0; finished = 0;
        while (!finished && n < 400) begin
            n++;
            case (mode)
                0: bus_grant = 1'b1;
                1: bus_grant = ($urandom_range(0, 3) != 0);
                2: begin
                    if (load_MAR && mars == 1) hold = 4;
                    bus_grant = (hold == 0);
                    if (hold > 0) hold--;
                end
                default: bus_grant = (n >= 6);
            endcase
            wdata = wd[beats % 32];
            @(negedge clock);
            if (n == 1) begin
                check("accept_busy", busy, 1);
                check("accept_bus_req", bus_req, 1);
                check("accept_no_mar", load_MAR, 0);
                check("accept_no_done", done, 0);
            end
            if (after2) begin
                check("regrant_req", bus_req, 1);
                check("regrant_no_mar", load_MAR, 0);
                check("regrant_no_beat", beat_ack, 0);
                after2 = 0;
            end
            if (load_MAR) begin
                check("addr_phase", sysbus, {3'b000, 5'(a + mars)});
                mars++;
            end
            if (beat_ack) begin
                check("data_cs", CS, 1);
                check("data_rnw", R_NW, !w);
                check("data_mdr_bus", MDR_bus, !w);
                check("data_load_mdr", load_MDR, w);
                if (w) check("data_wdata", sysbus, wd[beats % 32]);
                beats++;
                if (mode == 2 && beats == 2) after2 = 1;
            end else begin
                check("nodata_cs", CS, 0);
            end
            if (!beat_ack && !load_MAR) check("bus_released", sysbus, 8'hFF);
            if (mode == 0) begin
                check("t_mar", load_MAR, (n >= 2 && n <= 2*l + 2 && n % 2 == 0));
                check("t_data", beat_ack, (n >= 3 && n <= 2*l + 3 && n % 2 == 1));
            end
            if (mode == 3 && n <= 6) begin
                check("wait_bus_req", bus_req, 1);
                check("wait_no_mar", load_MAR, 0);
            end
            if (mode == 3 && n == 7) check("grant_to_addr", load_MAR, 1);
            if (rvalid) begin
                check("rdata", rdata, ref_mem[5'(a + rvs)]);
                rvs++;
            end
            if (done) begin
                finished = 1;
                check("done_not_busy", busy, 0);
                check("beat_count", beats, l + 1);
                check("mar_count", mars, l + 1);
                check("rvalid_count", rvs, w ? 0 : l + 1);
                if (mode == 0) check("latency", n, 2*l + 4);
            end
            if (!finished) begin
                @(posedge clock); #1;
            end
        end
        if (!finished) check("done_timeout", 0, 1);
        if (w) for (int k = 0; k <= l; k++) ref_mem[5'(a + k)] = wd[k];
    endtask

    initial begin
        int guard;
        n_reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; len = '0; wdata = '0; bus_grant = 1'b0;
        fill_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            fill_idx = 5'(i);
            fill_val = 8'($urandom);
            ref_mem[i] = fill_val;
            @(posedge clock); #1;
        end
        fill_en = 1'b0;
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_bus_req", bus_req, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_done", done, 0);
        check("rst_rdata", rdata, 0);
        check("rst_cs", CS, 0);
        check("rst_bus_z", sysbus, 8'hFF);
        @(posedge clock); #1;
        n_reset = 1'b1;
        @(posedge clock); #1;

        run_txn(1'b0, 5'd2, 5'd0, 0, 1'b0);
        run_txn(1'b1, 5'd30, 5'd2, 0, 1'b1);
        check("ram_30", mem[30], 8'hA1);
        check("ram_31", mem[31], 8'hA2);
        check("ram_0", mem[0], 8'hA3);
        run_txn(1'b0, 5'd29, 5'd3, 0, 1'b0);
        run_txn(1'b0, 5'd5, 5'd1, 3, 1'b0);
        run_txn(1'b0, 5'd10, 5'd3, 2, 1'b0);
        run_txn(1'b1, 5'd20, 5'd3, 2, 1'b0);

        // Reset in the middle of a write DATA cycle, away from any clock edge.
        @(posedge clock); #1;
        req = 1'b1; we = 1'b1; addr = 5'd7; len = 5'd4; wdata = 8'h3C; bus_grant = 1'b1;
        @(posedge clock); #1;
        req = 1'b0;
        guard = 0;
        do begin
            @(negedge clock);
            guard++;
        end while (!beat_ack && guard < 10);
        check("reset_reached_data", beat_ack, 1);
        #2 n_reset = 1'b0;
        #1;
        check("arst_bus_z", sysbus, 8'hFF);
        check("arst_busy", busy, 0);
        check("arst_bus_req", bus_req, 0);
        check("arst_beat_ack", beat_ack, 0);
        check("arst_cs", CS, 0);
        check("arst_load_mdr", load_MDR, 0);
        check("arst_load_mar", load_MAR, 0);
        check("arst_rdata", rdata, 0);
        @(posedge clock); #1;
        n_reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("post_rst_idle", busy, 0);
            check("post_rst_bus_z", sysbus, 8'hFF);
        end
        check("ram_7_untouched", mem[7], ref_mem[7]);
        @(posedge clock); #1;

        for (int t = 0; t < 20; t++) begin
            run_txn(1'($urandom), 5'($urandom), 5'($urandom_range(0, 5)),
                    ($urandom_range(0, 2) == 0) ? 0 : 1, 1'b0);
        end

        for (int i = 0; i < 32; i++) check("ram_final", mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
